// File: rtl/polar_encoder.sv
// Serial non-systematic polar encoder: load u via frozen-BRAM lookup, N_LOG in-place butterfly stages, stream x out.
// Define BIT_REVERSE_OUT_EN to emit the codeword in bit-reversed order.
module polar_encoder #(
    parameter int N_LOG      = 10,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] addr_to_frozen_bit_indication_bram,
    output logic                  enable_to_frozen_bit_indication_bram,
    input  logic                  data_from_frozen_bit_indication_bram,
    input  logic                  info_bit_in,
    input  logic                  info_bit_valid,
    output logic                  info_bit_ready,
    output logic                  code_bit_out,
    output logic                  code_bit_valid,
    input  logic                  code_bit_ready,
    output logic                  code_bit_last,
    output logic                  enc_fin
);

    localparam int N       = 1 << N_LOG;
    localparam int POS_W   = N_LOG + 1;
    localparam int STAGE_W = $clog2(N_LOG) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FILL,
        S_ENCODE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_u;
    logic [POS_W-1:0]   r_pos;
    logic [STAGE_W-1:0] r_stage;
    logic               r_first_fill;
    logic               r_frozen_q;

    logic               w_frozen;
    logic               w_pos_last;
    logic [N_LOG-1:0]   w_idx;
    logic [N_LOG-1:0]   w_out_idx;
    logic [N-1:0]       w_u_enc;

    assign w_idx      = r_pos[N_LOG-1:0];
    assign w_pos_last = (r_pos == POS_W'(N - 1));
    // BRAM output is only guaranteed on the first FILL cycle; later stall cycles use the captured copy
    assign w_frozen   = r_first_fill ? data_from_frozen_bit_indication_bram : r_frozen_q;

`ifdef BIT_REVERSE_OUT_EN
    always_comb begin
        w_out_idx = '0;
        for (int unsigned i = 0; i < N_LOG; i++)
            w_out_idx[i] = w_idx[N_LOG-1-i];
    end
`else
    assign w_out_idx = w_idx;
`endif

    always_comb begin
        w_u_enc = r_u;
        for (int unsigned s = 0; s < N_LOG; s++) begin
            if (r_stage == STAGE_W'(s)) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (((j >> s) & 1) == 0)
                        w_u_enc[j] = r_u[j] ^ r_u[j | (1 << s)];
                end
            end
        end
    end

    assign busy                                 = (r_state != S_IDLE);
    assign enable_to_frozen_bit_indication_bram = (r_state == S_FETCH);
    assign addr_to_frozen_bit_indication_bram   = (r_state == S_FETCH) ? ADDR_WIDTH'(w_idx) : '0;
    assign info_bit_ready                       = (r_state == S_FILL) && !w_frozen;
    assign code_bit_valid                       = (r_state == S_OUTPUT);
    assign code_bit_out                         = (r_state == S_OUTPUT) && r_u[w_out_idx];
    assign code_bit_last                        = (r_state == S_OUTPUT) && w_pos_last;
    assign enc_fin                              = (r_state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_u          <= '0;
            r_pos        <= '0;
            r_stage      <= '0;
            r_first_fill <= 1'b0;
            r_frozen_q   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_pos   <= '0;
                    end
                end
                S_FETCH: begin
                    r_first_fill <= 1'b1;
                    r_state      <= S_FILL;
                end
                S_FILL: begin
                    r_first_fill <= 1'b0;
                    if (r_first_fill)
                        r_frozen_q <= data_from_frozen_bit_indication_bram;
                    if (w_frozen || info_bit_valid) begin
                        r_u[w_idx] <= w_frozen ? 1'b0 : info_bit_in;
                        if (w_pos_last) begin
                            r_state <= S_ENCODE;
                            r_stage <= '0;
                        end else begin
                            r_pos   <= r_pos + POS_W'(1);
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_ENCODE: begin
                    r_u <= w_u_enc;
                    if (r_stage == STAGE_W'(N_LOG - 1)) begin
                        r_state <= S_OUTPUT;
                        r_pos   <= '0;
                    end else begin
                        r_stage <= r_stage + STAGE_W'(1);
                    end
                end
                S_OUTPUT: begin
                    if (code_bit_ready) begin
                        if (w_pos_last)
                            r_state <= S_DONE;
                        else
                            r_pos <= r_pos + POS_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_encoder.sv
// Randomized self-checking bench for polar_encoder (N_LOG=3) against a subset-XOR codeword model.
module tb_polar_encoder;

    localparam int N_LOG = 3;
    localparam int N     = 8;
    localparam int AW    = 4;
    localparam logic [7:0] MASK = 8'b0001_0111;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic          bram_q = 1'b0;
    logic          info_bit_in;
    logic          info_bit_valid;
    logic          info_bit_ready;
    logic          code_bit_out;
    logic          code_bit_valid;
    logic          code_bit_ready;
    logic          code_bit_last;
    logic          enc_fin;

    int checks = 0;
    int errors = 0;

    logic info_q[$];
    logic exp_q[$];
    int   bp_mode = 0;
    int   rgaps = 0;
    int   starve_left = 0;
    int   consumed = 0;
    int   bp_cnt = 0;

    polar_encoder #(.N_LOG(N_LOG), .ADDR_WIDTH(AW)) dut (
        .clk                                  (clk),
        .reset_n                              (reset_n),
        .start                                (start),
        .busy                                 (busy),
        .addr_to_frozen_bit_indication_bram   (bram_addr),
        .enable_to_frozen_bit_indication_bram (bram_en),
        .data_from_frozen_bit_indication_bram (bram_q),
        .info_bit_in                          (info_bit_in),
        .info_bit_valid                       (info_bit_valid),
        .info_bit_ready                       (info_bit_ready),
        .code_bit_out                         (code_bit_out),
        .code_bit_valid                       (code_bit_valid),
        .code_bit_ready                       (code_bit_ready),
        .code_bit_last                        (code_bit_last),
        .enc_fin                              (enc_fin)
    );

    always #5 clk = ~clk;

    // Frozen-bit BRAM with one cycle of read latency
    always @(posedge clk) if (bram_en) bram_q <= MASK[bram_addr[2:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_x(input logic [3:0] info);
        logic [7:0] u;
        logic [7:0] x;
        int k;
        u = '0;
        x = '0;
        k = 0;
        for (int i = 0; i < N; i++)
            if (!MASK[i]) begin
                u[i] = info[k];
                k++;
            end
        for (int j = 0; j < N; j++)
            for (int i = 0; i < N; i++)
                if ((i & j) == j) x[j] = x[j] ^ u[i];
        return x;
    endfunction

    function automatic logic [7:0] emit(input logic [7:0] x);
        logic [7:0] e;
        e = x;
`ifdef BIT_REVERSE_OUT_EN
        for (int p = 0; p < N; p++)
            e[p] = x[((p & 1) << 2) | (p & 2) | ((p >> 2) & 1)];
`endif
        return e;
    endfunction

    task automatic check_zero(input string name);
        chk(name, {busy, bram_en, bram_addr, info_bit_ready, code_bit_out,
                   code_bit_valid, code_bit_last, enc_fin}, 0);
    endtask

    // Output ready driver
    initial begin
        logic [3:0] pat;
        pat = 4'b1001;
        code_bit_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1:       code_bit_ready = pat[bp_cnt % 4];
                2:       code_bit_ready = 1'($urandom % 2);
                default: code_bit_ready = 1'b1;
            endcase
            bp_cnt++;
        end
    end

    // Info-bit source
    initial begin
        bit hs;
        info_bit_valid = 1'b0;
        info_bit_in    = 1'b0;
        forever begin
            @(negedge clk);
            hs = reset_n && info_bit_valid && info_bit_ready;
            if (consumed == 1 && starve_left > 0 && info_bit_ready && !info_bit_valid) begin
                chk("starve_no_bram_reread", bram_en, 0);
                starve_left--;
            end
            @(posedge clk);
            #1;
            if (hs && info_q.size() > 0) begin
                void'(info_q.pop_front());
                consumed++;
            end
            if (consumed == 1 && starve_left > 0) begin
                info_bit_valid = 1'b0;
            end else begin
                info_bit_valid = (info_q.size() > 0) && (rgaps == 0 || $urandom_range(3) != 0);
                info_bit_in    = (info_q.size() > 0) ? info_q[0] : 1'b0;
            end
        end
    end

    // Output scoreboard
    always @(negedge clk) begin
        if (reset_n && code_bit_valid) begin
            if (exp_q.size() == 0) begin
                chk("extra_code_bit", 1, 0);
            end else begin
                chk("code_bit", code_bit_out, exp_q[0]);
                chk("code_last", code_bit_last, exp_q.size() == 1);
                if (code_bit_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_cw(input logic [3:0] info, input int bp, input int gaps,
                          input int starve, input int poke);
        logic [7:0] e;
        int  cyc;
        bit  poked;
        bit  done;
        bit  busy_ok;
        e = emit(model_x(info));
        bp_mode = bp;
        rgaps = gaps;
        consumed = 0;
        starve_left = starve ? 5 : 0;
        for (int i = 0; i < 4; i++) info_q.push_back(info[i]);
        for (int p = 0; p < N; p++) exp_q.push_back(e[p]);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        poked = 0;
        done = 0;
        busy_ok = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!busy) busy_ok = 0;
            if (enc_fin) done = 1;
            start = poke != 0 && code_bit_valid && !poked;
            if (start) poked = 1;
        end
        start = 1'b0;
        chk("enc_fin_seen", done, 1);
        chk("busy_while_active", busy_ok, 1);
        if (bp == 0 && gaps == 0) chk("latency", cyc, 28 + (starve != 0 ? 5 : 0));
        @(negedge clk);
        chk("enc_fin_single", enc_fin, 0);
        chk("busy_back_idle", busy, 0);
        chk("all_bits_out", exp_q.size(), 0);
        chk("info_consumed", info_q.size(), 0);
        if (starve != 0) chk("starve_cycles", starve_left, 0);
    endtask

    initial begin
        chk("model_case1", model_x(4'b0001), 8'h0F);
        chk("model_case2", model_x(4'b1111), 8'h96);
`ifdef BIT_REVERSE_OUT_EN
        chk("model_bitrev_case1", emit(model_x(4'b0001)), 8'h55);
`endif
        repeat (2) @(negedge clk);
        check_zero("reset_outputs");
        reset_n = 1'b1;
        @(negedge clk);

        run_cw(4'b0001, 0, 0, 0, 0);
        run_cw(4'b1111, 0, 0, 0, 0);
        run_cw(4'b1111, 1, 0, 0, 0);
        run_cw(4'b1111, 0, 0, 1, 0);

        // Reset in the middle of ENCODE
        bp_mode = 0;
        rgaps = 0;
        consumed = 0;
        starve_left = 0;
        for (int i = 0; i < 4; i++) info_q.push_back(1'b1);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (18) @(negedge clk);
        reset_n = 1'b0;
        info_q.delete();
        exp_q.delete();
        #1 check_zero("reset_mid_encode");
        repeat (2) @(negedge clk);
        check_zero("reset_held");
        reset_n = 1'b1;
        @(negedge clk);
        run_cw(4'b0001, 0, 0, 0, 1);

        for (int t = 0; t < 10; t++)
            run_cw(4'($urandom), 2, 1, 0, int'($urandom % 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
